// File: rtl/encoder_4_2_seq.sv
// ---------------------------------------------------------------------------
// encoder_4_2_seq
//
// Registered event encoder. N request lines are captured into sticky pending
// bits. The binary index of one pending event is presented at a time on a
// valid/ready handshake. It is the inverse of the 2-to-4 decoder: the consumer
// receives and services one binary code at a time.
//
// Parameters
//   N    number of request lines (N >= 2)
//   W    width of the output index; must equal $clog2(N)
//
// Ports
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous active-high reset
//   I     in   N   request event lines, sampled on every clk edge
//   En    in   1   capture enable; I is ignored while En=0
//   Rdy   in   1   consumer ready; a handshake completes when V=1 and Rdy=1
//   Y     out  W   registered index of the presented event
//   V     out  1   registered valid; Y is meaningful only while V=1
//   Ovf   out  1   registered one-cycle pulse: a new event merged into a bit
//                  that was already pending, so one event was lost
//   Pend  out  N   registered pending-bit vector (visibility)
//
// Build option
//   ENCODER_ROUND_ROBIN_EN  when defined, selection rotates. The search starts
//                           one index above the last served index and wraps.
//                           When undefined, the highest pending index always
//                           wins and there is no Last register.
// ---------------------------------------------------------------------------
module encoder_4_2_seq #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] I,
    input  logic         En,
    input  logic         Rdy,
    output logic [W-1:0] Y,
    output logic         V,
    output logic         Ovf,
    output logic [N-1:0] Pend
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q,  pend_d;
    logic [W-1:0] y_q,     y_d;
    logic         v_q,     v_d;
    logic         ovf_q,   ovf_d;

    logic         hs;          // handshake completes this cycle
    logic [N-1:0] clr_vec;     // one-hot at Y on a handshake, else zero
    logic [N-1:0] new_ev;      // gated request lines
    logic [W-1:0] sel_idx;     // index chosen from the registered pending bits

    assign hs     = (state_q == HOLD) && Rdy;
    assign new_ev = I & {N{En}};

    for (genvar gi = 0; gi < N; gi++) begin : g_clr
        assign clr_vec[gi] = hs && (y_q == W'(gi));
    end

    // -----------------------------------------------------------------------
    // Selection. This logic uses only the registered pending vector, so there
    // is no combinational path from I or Rdy to Y or V.
    // -----------------------------------------------------------------------
`ifdef ENCODER_ROUND_ROBIN_EN
    logic [W-1:0]   last_q, last_d;
    logic [2*N-1:0] pend_dbl;
    logic [N-1:0]   pend_rot;
    logic [W:0]     rr_pos;

    // Rotate so that bit j of pend_rot is pending index (last+1+j) mod N.
    // The lowest set j is then the first hit of the wrap-around scan.
    always_comb begin
        pend_dbl = {pend_q, pend_q};
        pend_rot = N'(pend_dbl >> ({1'b0, last_q} + 1'b1));
        rr_pos   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (pend_rot[j]) begin
                rr_pos = {1'b0, last_q} + (W+1)'(j + 1);
            end
        end
        // rr_pos is at most 2N-1, so one conditional subtract gives the
        // index modulo N.
        if (rr_pos >= (W+1)'(N)) begin
            sel_idx = W'(rr_pos - (W+1)'(N));
        end else begin
            sel_idx = rr_pos[W-1:0];
        end
    end

    assign last_d = hs ? y_q : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority. The loop runs upward, so the highest set index is
    // assigned last and wins.
    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (pend_q[k]) begin
                sel_idx = W'(k);
            end
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Pending bits and overflow. A fresh request on the index that is being
    // cleared wins, so that bit stays set. That case is not an overflow,
    // because the old event was served.
    // -----------------------------------------------------------------------
    always_comb begin
        pend_d = (pend_q & ~clr_vec) | new_ev;
        ovf_d  = |(new_ev & pend_q & ~clr_vec);
    end

    // -----------------------------------------------------------------------
    // Presentation FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                v_d = 1'b0;
                if (pend_q != '0) begin
                    y_d     = sel_idx;
                    v_d     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Y is left untouched on return to IDLE; only V drops.
                if (Rdy) begin
                    v_d     = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                v_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            y_q     <= '0;
            v_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            v_q     <= v_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Y    = y_q;
    assign V    = v_q;
    assign Ovf  = ovf_q;
    assign Pend = pend_q;

endmodule

// File: doc/encoder_4_2_seq.md
Name: encoder_4_2_seq

Overview:
- Registered event encoder. It is the inverse of the team's 2-to-4 decoder: N one-hot/multi-hot event lines in, binary index of one pending event out.
- Events are latched as sticky pending bits and presented one at a time under a valid/ready handshake.
- Sits between interrupt-style request lines and a consumer that services one binary code at a time.

Parameters:
- N, 4, number of request lines (N >= 2).
- W, 2, output index width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- I  input  N  request event lines, sampled every clk edge.
- En  input  1  capture enable; when 0, I is ignored.
- Rdy  input  1  consumer ready; completes a handshake when V=1.
- Y  output  W  registered binary index of the presented event.
- V  output  1  registered valid; Y is meaningful only while V=1.
- Ovf  output  1  registered one-cycle pulse, event merged/lost.
- Pend  output  N  registered pending-bit vector (debug/visibility).

Behaviour:
- Reset is asynchronous, active-high. While rst=1: Pend=0, Y=0, V=0, Ovf=0, state=IDLE. Mid-operation reset drops all pending events and any presented code immediately.
- Pending update at each edge: Pend_next = (Pend & ~clr) | (I & {N{En}}).
  - clr is one-hot at index Y when a handshake completes this cycle, else 0.
  - A new I bit on the same index being cleared wins, so the bit stays set.
- Ovf_next = 1 iff any bit k has I[k]&En=1 and Pend[k]=1 and k is not being cleared this cycle. Otherwise Ovf_next=0, so it is a single-cycle pulse per offending cycle.
- FSM, two states:
  - IDLE: V=0. If Pend!=0, load Y with the selected index, set V=1, go to HOLD. If Pend==0, stay.
  - HOLD: V=1, Y held stable. If Rdy=1, clear Pend[Y], set V=0, go to IDLE. If Rdy=0, hold indefinitely with Y and V unchanged.
- Selection is fixed priority: the highest set index of Pend wins, matching the 4-to-2 priority encoder convention.
- Selection uses the registered Pend only. No combinational path from I or Rdy to Y or V.
- Latency: I[k]=1 sampled at edge t sets Pend[k] at t. With the FSM in IDLE, V=1 and Y=k after edge t+1.
- Throughput: at most one code per 2 cycles (HOLD→IDLE→HOLD).
- Handshake completes in the cycle where V=1 and Rdy=1. Rdy while V=0 has no effect.
- Y is not cleared on return to IDLE; it keeps the last value with V=0.
- En=0 blocks capture only. Already-pending events are still served.
- Width rule: Y is exactly W bits. Indices 0..N-1 only. For non-power-of-2 N, codes >= N never appear.

Optional Feature:
- Macro: ENCODER_ROUND_ROBIN_EN.
- Defined:
  - Selection is rotating. A registered pointer Last (W bits, reset value N-1) records the last served index.
  - Search starts at (Last+1) mod N, scanning upward with wrap-around. The first set Pend bit wins.
  - Last updates to Y on each completed handshake.
  - All other behaviour is unchanged.
- Undefined: fixed highest-index priority as above. No Last register is synthesized.

Test Plan:
- Reset mid-HOLD: with Pend=4'b1010 and V=1, assert rst asynchronously between edges → Pend=0, V=0, Y=0, Ovf=0 immediately; after release, no V without new I.
- Single event: En=1, I=4'b0100 for one cycle, Rdy=1 → V=1, Y=2 one edge later. Handshake clears Pend to 0 and V=0 on the next edge. Latency measured as 2 edges from I sample to V.
- Priority with stall: I=4'b1011 in one cycle, Rdy=0 for 5 cycles → Y=3 held stable with V=1 throughout. Then with Rdy=1, codes are served in order 3, 1, 0, each V pulse separated by an IDLE cycle.
- Enable gating: En=0, I=4'b1111 → Pend stays 0, V stays 0, Ovf stays 0. Then En=1, I=4'b0001 → Y=0, V=1.
- Overflow and merge:
  - Pend[1]=1 presented with Rdy=0; pulse I=4'b0010 again → Ovf=1 for exactly one cycle, Pend unchanged.
  - Repeat with I[1] in the handshake cycle (Rdy=1) → Ovf=0, Pend[1] remains 1, Y=1 re-presented.
- With ENCODER_ROUND_ROBIN_EN defined: hold I=4'b1111 with Rdy=1 continuously → served sequence is 0, 1, 2, 3, 0, … ; without the macro the sequence is 3, 3, 3, ….
